// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the DMA copy master, plus the copy FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_FIN  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/ahb_dma_copy_master.sv
// AHB-Lite master copying a block of words one SINGLE read/write pair at a time.
// Bus outputs are registered from the next-state decode so they align with the FSM.
module ahb_dma_copy_master
  import ahb_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             sys_root_clk,
  input  logic             sys_root_rst,
  input  logic             start,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       htrans,
  output logic [2:0]       hburst,
  output logic [2:0]       hsize,
  output logic             hwrite,
  output logic [31:0]      haddr,
  output logic [3:0]       hprot,
  output logic             hmastlock,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic             hresp,
  input  logic [31:0]      hrdata
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  dma_state_e       state_r, state_s;
  logic [31:0]      src_ptr_r, src_ptr_s;
  logic [31:0]      dst_ptr_r, dst_ptr_s;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic [31:0]      buf_r, buf_s;
  logic             err_r, err_s;
  logic [1:0]       htrans_r, htrans_s;
  logic             hwrite_r, hwrite_s;
  logic [31:0]      haddr_r, haddr_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state, pointer, counter, buffer and error-flag logic.
  always_comb begin
    state_s   = state_r;
    src_ptr_s = src_ptr_r;
    dst_ptr_s = dst_ptr_r;
    cnt_s     = cnt_r;
    buf_s     = buf_r;
    err_s     = err_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          err_s = 1'b0;
          if (cfg_len != CNT_ZERO) begin
            src_ptr_s = {cfg_src[31:2], 2'b00};
            dst_ptr_s = {cfg_dst[31:2], 2'b00};
            cnt_s     = cfg_len;
            state_s   = ST_RD_A;
          end else begin
            state_s = ST_FIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (hready) state_s = ST_RD_D;
        else        state_s = ST_RD_A;
      end
      ST_RD_D: begin
        if (!hready) begin
          state_s = ST_RD_D;
        end else if (hresp == HRESP_ERROR) begin
          err_s   = 1'b1;
          state_s = ST_FIN;
        end else begin
          buf_s   = hrdata;
          state_s = ST_WR_A;
        end
      end
      ST_WR_A: begin
        if (hready) state_s = ST_WR_D;
        else        state_s = ST_WR_A;
      end
      ST_WR_D: begin
        if (!hready) begin
          state_s = ST_WR_D;
        end else if (hresp == HRESP_ERROR) begin
          err_s   = 1'b1;
          state_s = ST_FIN;
        end else begin
          src_ptr_s = src_ptr_r + 32'd4;
          dst_ptr_s = dst_ptr_r + 32'd4;
          cnt_s     = cnt_r - CNT_ONE;
          // abort only takes effect once the current word is fully written
          if ((cnt_r == CNT_ONE) || abort) state_s = ST_FIN;
          else                             state_s = ST_RD_A;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus and status values for the coming cycle, decoded from the next state.
  always_comb begin
    htrans_s = HTRANS_IDLE;
    hwrite_s = 1'b0;
    haddr_s  = haddr_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_s)
      ST_RD_A: begin
        htrans_s = HTRANS_NONSEQ;
        haddr_s  = src_ptr_s;
        busy_s   = 1'b1;
      end
      ST_WR_A: begin
        htrans_s = HTRANS_NONSEQ;
        hwrite_s = 1'b1;
        haddr_s  = dst_ptr_s;
        busy_s   = 1'b1;
      end
      ST_RD_D: busy_s = 1'b1;
      ST_WR_D: busy_s = 1'b1;
      ST_FIN:  done_s = 1'b1;
      ST_IDLE: done_s = 1'b0;
      default: done_s = 1'b0;
    endcase
  end

  // State, datapath and registered bus outputs.
  always_ff @(posedge sys_root_clk) begin
    if (sys_root_rst) begin
      state_r   <= ST_IDLE;
      src_ptr_r <= 32'h0000_0000;
      dst_ptr_r <= 32'h0000_0000;
      cnt_r     <= CNT_ZERO;
      buf_r     <= 32'h0000_0000;
      err_r     <= 1'b0;
      htrans_r  <= HTRANS_IDLE;
      hwrite_r  <= 1'b0;
      haddr_r   <= 32'h0000_0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      src_ptr_r <= src_ptr_s;
      dst_ptr_r <= dst_ptr_s;
      cnt_r     <= cnt_s;
      buf_r     <= buf_s;
      err_r     <= err_s;
      htrans_r  <= htrans_s;
      hwrite_r  <= hwrite_s;
      haddr_r   <= haddr_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // The read buffer doubles as HWDATA: it only changes on a read completion,
  // so it is stable throughout every write data phase.
  assign hwdata    = buf_r;
  assign htrans    = htrans_r;
  assign hwrite    = hwrite_r;
  assign haddr     = haddr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign hburst    = HBURST_SINGLE;
  assign hsize     = HSIZE_WORD;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_dma_copy_master.sv
// Self-checking bench: AHB slave/memory model with wait states and ERROR injection,
// a vector table of directed copies, hand sequences for reset, and randomized copies.
module tb_ahb_dma_copy_master;

  localparam int LEN_W  = 16;
  localparam int BUDGET = 2000;

  logic             sys_root_clk = 1'b0;
  logic             sys_root_rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      cfg_src = 32'h0;
  logic [31:0]      cfg_dst = 32'h0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             abort = 1'b0;
  logic             busy, done, err, hwrite, hmastlock;
  logic [1:0]       htrans;
  logic [2:0]       hburst, hsize;
  logic [31:0]      haddr, hwdata;
  logic [3:0]       hprot;
  logic             hready = 1'b1;
  logic             hresp = 1'b0;
  logic [31:0]      hrdata = 32'h0;

  ahb_dma_copy_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
    .sys_root_clk(sys_root_clk), .sys_root_rst(sys_root_rst), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hprot(hprot),
    .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  always #5 sys_root_clk = ~sys_root_clk;

  typedef struct {
    string       name;
    logic [31:0] src, dst;
    int          len, aw, dw, err_idx, abort_word;
    int          exp_words;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
  } xfer_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- slave / memory model ----------------
  logic [31:0] mem [logic [31:0]];
  xfer_t       log_q[$];
  int          cur_aw = 0, cur_dw = 0, cur_err_idx = 0;
  int          aw_left = 0, rd_accepts = 0, dp_wait = 0;
  bit          dp_valid = 0, dp_write = 0, dp_err = 0, err_half = 0;
  logic [31:0] dp_addr = 32'h0;
  bit          hold_a = 0, hold_d = 0;
  logic [1:0]  hold_trans = 2'b00;
  logic [31:0] hold_addr = 32'h0, hold_wdata = 32'h0;

  always @(negedge sys_root_clk) begin
    if (hold_a) begin
      chk("addr_hold_htrans", {30'h0, htrans}, {30'h0, hold_trans});
      chk("addr_hold_haddr", haddr, hold_addr);
    end
    if (hold_d) chk("wdata_hold", hwdata, hold_wdata);
    hold_a = 0;
    hold_d = 0;
    if (sys_root_rst) begin
      dp_valid = 0; err_half = 0; hready = 1'b1; hresp = 1'b0; aw_left = cur_aw;
    end else begin
      hresp  = 1'b0;
      hrdata = $urandom;
      if (dp_valid) begin
        if (dp_err) begin
          hresp = 1'b1;
          if (!err_half) begin hready = 1'b0; err_half = 1; end
          else begin hready = 1'b1; err_half = 0; dp_valid = 0; end
        end else if (dp_wait > 0) begin
          hready = 1'b0;
          dp_wait--;
          if (dp_write) begin hold_d = 1; hold_wdata = hwdata; end
        end else begin
          hready = 1'b1;
          if (dp_write) mem[dp_addr] = hwdata;
          else hrdata = mem.exists(dp_addr) ? mem[dp_addr] : init_val(dp_addr);
          dp_valid = 0;
        end
      end else if (htrans == 2'b10) begin
        if (aw_left > 0) begin
          hready = 1'b0; aw_left--;
          hold_a = 1; hold_trans = htrans; hold_addr = haddr;
        end else begin
          hready = 1'b1; aw_left = cur_aw;
          log_q.push_back('{addr: haddr, wr: hwrite});
          if (!hwrite) rd_accepts++;
          dp_valid = 1; dp_addr = haddr; dp_write = hwrite; dp_wait = cur_dw;
          dp_err = !hwrite && (rd_accepts == cur_err_idx);
          err_half = 0;
        end
      end else begin
        hready = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int per = 4 + 2 * v.aw + 2 * v.dw;
    if (v.err_idx != 0 && v.err_idx <= v.len) begin
      r.exp_words = v.err_idx - 1;
      r.exp_err   = 1;
      r.exp_lat   = r.exp_words * per + (1 + v.aw) + 2 + 1;
    end else begin
      r.exp_words = v.len;
      r.exp_err   = 0;
      r.exp_lat   = v.len * per + 1;
    end
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] s, input logic [31:0] d,
                              input int len, input int aw, input int dw, input int ei,
                              input int ab, input int ew, input bit ee, input int el);
    vec_t v;
    v.name = nm; v.src = s; v.dst = d; v.len = len; v.aw = aw; v.dw = dw;
    v.err_idx = ei; v.abort_word = ab; v.exp_words = ew; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          lat;
    int          nx;
    logic [31:0] s0, d0;
    s0 = {v.src[31:2], 2'b00};
    d0 = {v.dst[31:2], 2'b00};
    mem.delete(); log_q.delete();
    rd_accepts = 0; cur_aw = v.aw; cur_dw = v.dw; cur_err_idx = v.err_idx; aw_left = v.aw;
    @(negedge sys_root_clk); #1;
    start = 1'b1; cfg_src = v.src; cfg_dst = v.dst; cfg_len = v.len[LEN_W-1:0];
    lat = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge sys_root_clk); #1;
      if (c == 1) begin
        chk({v.name, "_err_cleared"}, {31'h0, err}, 32'h0);
        chk({v.name, "_busy_after_start"}, {31'h0, busy}, {31'h0, (v.len != 0)});
      end
      if (c == 2 && v.len != 0) begin
        start = 1'b1; cfg_len = 16'd7; cfg_src = 32'hDEAD_0000; cfg_dst = 32'hBEEF_0000;
      end else begin
        start = 1'b0;
      end
      if (v.abort_word != 0 && rd_accepts >= v.abort_word) abort = 1'b1;
      if (done === 1'b1) begin lat = c; break; end
    end
    start = 1'b0;
    chk({v.name, "_done_latency"}, lat, v.exp_lat);
    chk({v.name, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
    chk({v.name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    abort = 1'b0;
    @(negedge sys_root_clk); #1;
    chk({v.name, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    chk({v.name, "_idle_htrans"}, {30'h0, htrans}, 32'h0);
    chk({v.name, "_err_sticky"}, {31'h0, err}, {31'h0, v.exp_err});
    nx = 2 * v.exp_words + (v.exp_err ? 1 : 0);
    chk({v.name, "_nonseq_count"}, log_q.size(), nx);
    for (int i = 0; i < nx && i < log_q.size(); i++) begin
      logic [31:0] ea;
      ea = (i % 2 == 0) ? s0 + 32'(4 * (i / 2)) : d0 + 32'(4 * (i / 2));
      chk($sformatf("%s_xfer%0d_addr", v.name, i), log_q[i].addr, ea);
      chk($sformatf("%s_xfer%0d_write", v.name, i), {31'h0, log_q[i].wr}, {31'h0, (i % 2 == 1)});
    end
    for (int i = 0; i < v.exp_words; i++) begin
      logic [31:0] da;
      da = d0 + 32'(4 * i);
      chk($sformatf("%s_dst%0d", v.name, i), mem.exists(da) ? mem[da] : 32'hXXXX_XXXX,
          init_val(s0 + 32'(4 * i)));
    end
    chk({v.name, "_dst_after_untouched"}, {31'h0, mem.exists(d0 + 32'(4 * v.exp_words))}, 32'h0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  bit   found;

  initial begin
    tbl[0] = mk("copy4",     32'h0000_0100, 32'h0001_0000, 4, 0, 0, 0, 0, 4, 0, 17);
    tbl[1] = mk("copy4_ws",  32'h0000_0100, 32'h0001_0000, 4, 1, 2, 0, 0, 4, 0, 41);
    tbl[2] = mk("len0",      32'h0000_0100, 32'h0001_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3] = mk("rd_err3",   32'h0000_0800, 32'h0002_0000, 5, 0, 0, 3, 0, 2, 1, 12);
    tbl[4] = mk("wrap",      32'hFFFF_FFF8, 32'h0000_2000, 3, 0, 0, 0, 0, 3, 0, 13);
    tbl[5] = mk("lowbits",   32'h0000_0207, 32'h0003_000A, 2, 0, 1, 0, 0, 2, 0, 13);
    tbl[6] = mk("abort_w2",  32'h0000_4000, 32'h0000_5000, 10, 0, 0, 0, 2, 2, 0, 9);

    repeat (3) @(posedge sys_root_clk);
    @(negedge sys_root_clk);
    chk("rst_htrans", {30'h0, htrans}, 32'h0);
    chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_busy_done_err", {29'h0, busy, done, err}, 32'h0);
    chk("const_hburst_hsize", {26'h0, hburst, hsize}, {26'h0, 3'b000, 3'b010});
    chk("const_hprot_lock", {27'h0, hprot, hmastlock}, {27'h0, 4'b0011, 1'b0});
    #1 sys_root_rst = 1'b0;

    for (int t = 0; t < 7; t++) run_vec(tbl[t]);

    // reset during the write address phase abandons the copy at once
    mem.delete(); log_q.delete(); rd_accepts = 0;
    cur_aw = 0; cur_dw = 0; cur_err_idx = 0; aw_left = 0;
    @(negedge sys_root_clk); #1;
    start = 1'b1; cfg_src = 32'hFFFF_FFF8; cfg_dst = 32'h0000_3000; cfg_len = 16'd3;
    @(negedge sys_root_clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (htrans == 2'b10 && hwrite) begin found = 1; break; end
      @(negedge sys_root_clk); #1;
    end
    chk("rst_mid_reached_wr_a", {31'h0, found}, 32'h1);
    sys_root_rst = 1'b1;
    @(negedge sys_root_clk); #1;
    chk("rst_mid_htrans", {30'h0, htrans}, 32'h0);
    chk("rst_mid_busy_done", {30'h0, busy, done}, 32'h0);
    chk("rst_mid_hwdata", hwdata, 32'h0);
    sys_root_rst = 1'b0;
    repeat (2) begin @(negedge sys_root_clk); #1; end
    chk("rst_mid_stays_idle", {30'h0, htrans}, 32'h0);

    for (int r = 0; r < 8; r++) begin
      rv.name    = $sformatf("rnd%0d", r);
      rv.len     = $urandom_range(1, 6);
      rv.aw      = $urandom_range(0, 2);
      rv.dw      = $urandom_range(0, 2);
      rv.src     = 32'h1000_0000 | (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(0, 3));
      rv.dst     = 32'h2000_0000 | (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(0, 3));
      rv.err_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rv.len) : 0;
      rv.abort_word = 0;
      run_vec(model(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_dma_copy_master.md
Name: ahb_dma_copy_master

Overview:
AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address, one single transfer at a time. It drives the bus-master side of the fabric that serves the ITCM/DTCM SRAM bridges. Typical uses are bootloader image relocation and DTCM fill/clear, offloading the core. Configuration is sampled from a simple start/len/src/dst port; status is returned as busy/done/err.

Parameters:
LEN_W, 16, width of word-count register; maximum copy is 2^LEN_W-1 words.
HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).

Ports:
sys_root_clk  in  1  system clock; all logic on rising edge
sys_root_rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; accepted only when busy=0
cfg_src  in  32  source byte address; bits[1:0] ignored (forced 0)
cfg_dst  in  32  destination byte address; bits[1:0] ignored (forced 0)
cfg_len  in  LEN_W  number of words to copy
abort  in  1  level request to stop at the next word boundary
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse (normal, abort or error)
err  out  1  sticky bus-error flag; cleared on next accepted start
htrans  out  2  AHB HTRANS; only IDLE(00) or NONSEQ(10)
hburst  out  3  constant 3'b000 (SINGLE)
hsize  out  3  constant 3'b010 (word)
hwrite  out  1  AHB HWRITE
haddr  out  32  AHB HADDR
hprot  out  4  constant HPROT_VAL
hmastlock  out  1  constant 0
hwdata  out  32  AHB HWDATA; valid in write data phase
hready  in  1  bus HREADY
hresp  in  1  AHB-Lite HRESP (1 = ERROR)
hrdata  in  32  AHB HRDATA

Behaviour:
- Reset values: htrans=00, hwrite=0, haddr=0, hwdata=0, busy=0, done=0, err=0. Internal state returns to IDLE, and the pointers, counter and buffer are cleared. Reset mid-transfer abandons the transfer immediately.
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE:
  - start with cfg_len!=0: latch src/dst/len, clear err, go to RD_A, busy=1.
  - start with cfg_len==0: go to FIN with no bus activity.
  - start while busy: ignored.
- RD_A: htrans=NONSEQ, hwrite=0, haddr=src_ptr. Held unchanged while hready=0. On hready=1, go to RD_D.
- RD_D: htrans=IDLE. Wait for hready=1.
  - hresp=1: set err, go to FIN.
  - Otherwise: buffer<=hrdata, go to WR_A.
- WR_A: htrans=NONSEQ, hwrite=1, haddr=dst_ptr. Held while hready=0. On hready=1, go to WR_D.
- WR_D: htrans=IDLE; hwdata=buffer, held stable for the whole data phase. Wait for hready=1.
  - hresp=1: set err, go to FIN.
  - Otherwise: src_ptr+=4, dst_ptr+=4, cnt-=1.
  - Then go to FIN if cnt reaches 0 or abort=1; else go to RD_A.
- ERROR response: the two-cycle response (hready=0,hresp=1 then hready=1,hresp=1) is tolerated. No new NONSEQ is issued, because htrans is already IDLE in data phases.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- abort:
  - Sampled only at WR_D completion.
  - Never cancels an address phase already on the bus.
  - An abort during the read of a word still completes that word's write.
- Pointer arithmetic is modulo 2^32; wrap from 0xFFFF_FFFC to 0 is allowed, and no address check is performed.
- Zero-wait throughput: 4 cycles per word. The first NONSEQ appears on the cycle after start. For N words, done asserts 4N+1 cycles after start.
- err stays high after FIN until the next accepted start or reset.

Decomposition:
- Shared package ahb_pkg:
  - constants HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, HRESP_OKAY/ERROR
  - state typedef for this FSM
- Single module; no sub-module is warranted.

Test Plan:
- Copy 4 words src=0x0000_0100 to dst=0x0001_0000, zero-wait memory model -> dst reads back the source data, 8 NONSEQ transfers alternating read/write, done pulses 17 cycles after start, err=0.
- Same copy with slave inserting 2 wait states per data phase and 1 on address -> haddr/htrans/hwdata held stable during hready=0, data copied correctly, done late by the expected cycles.
- cfg_len=0 -> done 1 cycle after start, htrans stays IDLE, busy never observed high beyond FIN.
- Slave returns two-cycle ERROR on the 3rd read -> err=1, exactly 2 words written, no further NONSEQ, done pulses; the next start clears err.
- abort asserted during word 2 read of a 10-word copy -> word 2 fully written, FIN; dst word 3 untouched.
- src=0xFFFF_FFF8, len=3 -> read addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; reset asserted mid-WR_A -> next cycle htrans=00, busy=0, done=0.
